// File: rtl/testpattern_multi.sv
// Test-pattern generator on a sync-stripped sample stream: checkerboard, colour bars, gray ramp, border.
// Define TESTPATTERN_MOTION_EN to invert the checkerboard on every frame.
module testpattern_multi #(
  parameter int         COLOR_W      = 7,
  parameter logic [9:0] H_START_NTSC = 10'd120,
  parameter logic [9:0] H_STOP_NTSC  = 10'd760,
  parameter logic [9:0] H_START_PAL  = 10'd128,
  parameter logic [9:0] H_STOP_PAL   = 10'd768,
  parameter logic [8:0] V_START_NTSC = 9'd18,
  parameter logic [8:0] V_STOP_NTSC  = 9'd258,
  parameter logic [8:0] V_START_PAL  = 9'd22,
  parameter logic [8:0] V_STOP_PAL   = 9'd310
) (
  input  logic                     VCLK,
  input  logic                     RST,
  input  logic                     palmode,
  input  logic [1:0]               pattern_sel,
  input  logic                     vdata_sync_valid_i,
  input  logic [3:0]               vdata_sync_i,
  output logic                     vdata_valid_o,
  output logic [4+3*COLOR_W-1:0]   vdata_o
);

  localparam int         SB         = 3 * COLOR_W;
  localparam logic [9:0] BAR_W_NTSC = (H_STOP_NTSC - H_START_NTSC) >> 3;
  localparam logic [9:0] BAR_W_PAL  = (H_STOP_PAL - H_START_PAL) >> 3;
  localparam logic [31:0] CMAX      = 32'((64'd1 << COLOR_W) - 64'd1);

  logic [9:0] hcnt;
  logic [8:0] vcnt;
  logic [1:0] pattern;
  logic [2:0] idx;
  logic [9:0] sub;
  logic       phase;

  // Edges are judged against the sync bits already sitting in the output register.
  logic fall_h, fall_v;
  assign fall_h = vdata_o[SB+1] & ~vdata_sync_i[1];
  assign fall_v = vdata_o[SB+3] & ~vdata_sync_i[3];

  logic [9:0] h_start, h_stop, bar_w, xpos;
  logic [8:0] v_start, v_stop;
  logic       active, edge_px;
  assign h_start = palmode ? H_START_PAL : H_START_NTSC;
  assign h_stop  = palmode ? H_STOP_PAL  : H_STOP_NTSC;
  assign v_start = palmode ? V_START_PAL : V_START_NTSC;
  assign v_stop  = palmode ? V_STOP_PAL  : V_STOP_NTSC;
  assign bar_w   = palmode ? BAR_W_PAL   : BAR_W_NTSC;
  assign xpos    = hcnt - h_start;
  assign active  = (hcnt >= h_start) && (hcnt < h_stop) && (vcnt >= v_start) && (vcnt < v_stop);
  assign edge_px = (vcnt == v_start) || (vcnt == v_stop - 9'd1) ||
                   (hcnt == h_start) || (hcnt == h_stop - 10'd1);

  // Bar state restarts on the first sample of every active line.
  logic [2:0] cur_idx;
  logic [9:0] cur_sub;
  assign cur_idx = (xpos == 10'd0) ? 3'd0  : idx;
  assign cur_sub = (xpos == 10'd0) ? 10'd0 : sub;

  logic [31:0] gray_ext;
  logic [COLOR_W-1:0] gray;
  assign gray_ext = {24'd0, xpos[9:2]};
  assign gray     = (gray_ext > CMAX) ? CMAX[COLOR_W-1:0] : gray_ext[COLOR_W-1:0];

  logic [COLOR_W-1:0] r_d, g_d, b_d;
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (active) begin
      case (pattern)
        2'd0: begin
          r_d = {COLOR_W{xpos[0] ^ vcnt[0] ^ phase}};
          g_d = r_d;
          b_d = r_d;
        end
        2'd1: begin
          r_d = {COLOR_W{~cur_idx[1]}};
          g_d = {COLOR_W{~cur_idx[2]}};
          b_d = {COLOR_W{~cur_idx[0]}};
        end
        2'd2: begin
          r_d = gray;
          g_d = gray;
          b_d = gray;
        end
        default: begin
          r_d = {COLOR_W{edge_px}};
          g_d = r_d;
          b_d = r_d;
        end
      endcase
    end
  end

  always_ff @(posedge VCLK) begin
    if (RST) begin
      vdata_valid_o <= 1'b0;
      vdata_o       <= '0;
      hcnt          <= '0;
      vcnt          <= '0;
      pattern       <= '0;
      idx           <= '0;
      sub           <= '0;
    end else begin
      vdata_valid_o <= vdata_sync_valid_i;
      if (vdata_sync_valid_i) begin
        vdata_o <= {vdata_sync_i, r_d, g_d, b_d};
        if (fall_h)
          hcnt <= '0;
        else if (hcnt != 10'h3FF)
          hcnt <= hcnt + 10'd1;
        if (fall_v)
          vcnt <= '0;
        else if (fall_h && vcnt != 9'h1FF)
          vcnt <= vcnt + 9'd1;
        if (fall_v)
          pattern <= pattern_sel;
        if (active) begin
          if (cur_sub == bar_w - 10'd1) begin
            sub <= '0;
            idx <= (cur_idx == 3'd7) ? 3'd7 : cur_idx + 3'd1;
          end else begin
            sub <= cur_sub + 10'd1;
            idx <= cur_idx;
          end
        end
      end
    end
  end

`ifdef TESTPATTERN_MOTION_EN
  always_ff @(posedge VCLK) begin
    if (RST)
      phase <= 1'b0;
    else if (vdata_sync_valid_i && fall_v)
      phase <= ~phase;
  end
`else
  assign phase = 1'b0;
`endif

endmodule
